vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 93 +++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v counters, registered sync/enable/coordinate outputs.
// Latency: outputs lag the counters by 1 Clk; free-running, no backpressure (en only idles the block).
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       Clk,
  input  logic       reset_rtl_0,
  input  logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       vde,
  output logic [9:0] drawX,
  output logic [9:0] drawY,
  output logic       pix_ce,
  output logic       frame_start
);

  localparam int HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  logic [DW-1:0] r_d;
  logic [HW-1:0] r_hc;
  logic [VW-1:0] r_vc;

  logic r_hsync, r_vsync, r_vde, r_pix_ce, r_frame_start;
  logic [9:0] r_drawx, r_drawy;

  logic w_d_last, w_h_last, w_v_last;
  logic w_h_sync, w_v_sync;

  assign w_d_last = (r_d  == DW'(CLK_DIV - 1));
  assign w_h_last = (r_hc == HW'(HT - 1));
  assign w_v_last = (r_vc == VW'(VT - 1));
  assign w_h_sync = (r_hc >= HW'(H_VISIBLE + H_FP)) && (r_hc < HW'(H_VISIBLE + H_FP + H_SYNC));
  assign w_v_sync = (r_vc >= VW'(V_VISIBLE + V_FP)) && (r_vc < VW'(V_VISIBLE + V_FP + V_SYNC));

  // Disabling clears the counters so the next enable starts a fresh frame at (0,0).
  always_ff @(posedge Clk) begin
    if (!reset_rtl_0 || !en) begin
      r_d  <= '0;
      r_hc <= '0;
      r_vc <= '0;
    end else begin
      r_d <= w_d_last ? '0 : r_d + 1'b1;
      if (w_d_last) begin
        r_hc <= w_h_last ? '0 : r_hc + 1'b1;
        if (w_h_last) begin
          r_vc <= w_v_last ? '0 : r_vc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset_rtl_0) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_vde         <= 1'b0;
      r_pix_ce      <= 1'b0;
      r_frame_start <= 1'b0;
      r_drawx       <= '0;
      r_drawy       <= '0;
    end else begin
      r_hsync       <= !w_h_sync;
      r_vsync       <= !w_v_sync;
      r_vde         <= en && (r_hc < HW'(H_VISIBLE)) && (r_vc < VW'(V_VISIBLE));
      r_pix_ce      <= en && w_d_last;
      r_frame_start <= en && (r_d == '0) && (r_hc == '0) && (r_vc == '0);
      r_drawx       <= 10'(r_hc);
      r_drawy       <= 10'(r_vc);
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign vde         = r_vde;
  assign pix_ce      = r_pix_ce;
  assign frame_start = r_frame_start;
  assign drawX       = r_drawx;
  assign drawY       = r_drawy;

endmodule
